// File: rtl/call_stack_ctrl.sv
// Arbiter/sequencer for the return-address stack: grants one of irq/ret/call
// per two cycles, drives the stack strobes and tracks occupancy and errors.
module call_stack_ctrl #(
  parameter int AW    = 9,
  parameter int DEPTH = 2,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          call_req,
  input  logic [AW-1:0] call_addr,
  input  logic          ret_req,
  input  logic          irq_req,
  input  logic [AW-1:0] irq_addr,
  output logic          call_ack,
  output logic          ret_ack,
  output logic          irq_ack,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [AW-1:0] stk_in,
  input  logic [AW-1:0] stk_top,
  output logic [AW-1:0] ret_addr,
  output logic          ret_valid,
  output logic [DW-1:0] depth,
  output logic          busy,
  output logic          ovf_err,
  output logic          udf_err,
  input  logic          err_clr
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;
  typedef enum logic [1:0] {OP_CALL = 2'd0, OP_RET = 2'd1, OP_IRQ = 2'd2} op_t;

  state_t        state_r, state_d;
  op_t           op_r, op_d;
  logic [AW-1:0] addr_r, addr_d;
  logic [DW-1:0] depth_r;
  logic [AW-1:0] ret_addr_r;
  logic          ret_valid_r;
  logic          ovf_r, udf_r;

  logic exec_s, is_ret_s, full_s, empty_s;
  logic push_s, pop_s, ovf_set_s, udf_set_s;

  // Next-state logic: arbitrate in IDLE (irq > ret > call), always leave EXEC.
  always_comb begin
    state_d = state_r;
    op_d    = op_r;
    addr_d  = addr_r;
    case (state_r)
      IDLE: begin
        if (irq_req) begin
          op_d    = OP_IRQ;
          addr_d  = irq_addr;
          state_d = EXEC;
        end else if (ret_req) begin
          op_d    = OP_RET;
          addr_d  = '0;
          state_d = EXEC;
        end else if (call_req) begin
          op_d    = OP_CALL;
          addr_d  = call_addr;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // EXEC-cycle decode; gating with rst_n aborts an op caught by reset.
  always_comb begin
    exec_s    = (state_r == EXEC) && rst_n;
    is_ret_s  = (op_r == OP_RET);
    full_s    = (depth_r == DW'(DEPTH));
    empty_s   = (depth_r == '0);
    push_s    = exec_s && !is_ret_s;
    pop_s     = exec_s && is_ret_s && !empty_s;
    ovf_set_s = push_s && full_s;
    udf_set_s = exec_s && is_ret_s && empty_s;
  end

  // State, latched op, occupancy, popped address and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= OP_CALL;
      addr_r      <= '0;
      depth_r     <= '0;
      ret_addr_r  <= '0;
      ret_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
    end else begin
      state_r     <= state_d;
      op_r        <= op_d;
      addr_r      <= addr_d;
      ret_valid_r <= exec_s && is_ret_s;
      if (exec_s && is_ret_s) begin
        ret_addr_r <= empty_s ? '0 : stk_top;
      end
      // A push into a full stack drops the bottom entry, so depth holds.
      if (push_s && !full_s) begin
        depth_r <= depth_r + DW'(1);
      end else if (pop_s) begin
        depth_r <= depth_r - DW'(1);
      end
      ovf_r <= ovf_set_s | (ovf_r & ~err_clr);
      udf_r <= udf_set_s | (udf_r & ~err_clr);
    end
  end

  assign call_ack  = exec_s && (op_r == OP_CALL);
  assign ret_ack   = exec_s && is_ret_s;
  assign irq_ack   = exec_s && (op_r == OP_IRQ);
  assign stk_push  = push_s;
  assign stk_pop   = pop_s;
  assign stk_in    = push_s ? addr_r : '0;
  assign ret_addr  = ret_addr_r;
  assign ret_valid = ret_valid_r;
  assign depth     = depth_r;
  assign busy      = (state_r == EXEC);
  assign ovf_err   = ovf_r;
  assign udf_err   = udf_r;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: a queue-based stack model checked every
// cycle, plus literal expectations from the hand-worked scenarios.
module tb_call_stack_ctrl;
  localparam int AW = 9;
  localparam int DEPTH = 2;
  localparam int DW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          call_req = 1'b0, ret_req = 1'b0, irq_req = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] call_addr = '0, irq_addr = '0;
  logic          call_ack, ret_ack, irq_ack, stk_push, stk_pop, ret_valid, busy;
  logic          ovf_err, udf_err;
  logic [AW-1:0] stk_in, stk_top, ret_addr;
  logic [DW-1:0] depth;

  call_stack_ctrl #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .call_req(call_req), .call_addr(call_addr), .ret_req(ret_req),
    .irq_req(irq_req), .irq_addr(irq_addr),
    .call_ack(call_ack), .ret_ack(ret_ack), .irq_ack(irq_ack),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_in(stk_in), .stk_top(stk_top),
    .ret_addr(ret_addr), .ret_valid(ret_valid), .depth(depth), .busy(busy),
    .ovf_err(ovf_err), .udf_err(udf_err), .err_clr(err_clr)
  );

  // Stack environment: 2-entry shift stack without reset.
  logic [AW-1:0] stk_mem [0:1];
  assign stk_top = stk_mem[0];
  always_ff @(posedge clk) begin
    if (stk_push) begin
      stk_mem[1] <= stk_mem[0];
      stk_mem[0] <= stk_in;
    end else if (stk_pop) begin
      stk_mem[0] <= stk_mem[1];
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: valid entries as a queue (front = top), op in flight.
  logic [AW-1:0] mq[$];
  bit            m_exec = 1'b0;
  int            m_op = 0;  // 0 call, 1 ret, 2 irq
  logic [AW-1:0] m_addr = '0;
  bit            m_rv = 1'b0;
  logic [AW-1:0] m_ra = '0;
  bit            m_ovf = 1'b0, m_udf = 1'b0;

  task automatic model_step();
    bit so, su;
    logic [AW-1:0] dropped;
    so = 1'b0;
    su = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_exec = 1'b0; m_rv = 1'b0; m_ra = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (m_exec) begin
        if (m_op == 1) begin
          if (mq.size() > 0) m_ra = mq.pop_front();
          else begin m_ra = '0; su = 1'b1; end
          m_rv = 1'b1;
        end else begin
          mq.push_front(m_addr);
          if (mq.size() > DEPTH) begin dropped = mq.pop_back(); so = 1'b1; end
        end
        m_exec = 1'b0;
      end else if (irq_req || ret_req || call_req) begin
        m_exec = 1'b1;
        if (irq_req) begin m_op = 2; m_addr = irq_addr; end
        else if (ret_req) m_op = 1;
        else begin m_op = 0; m_addr = call_addr; end
      end
      m_ovf = so || (m_ovf && !err_clr);
      m_udf = su || (m_udf && !err_clr);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, on the falling edge.
  initial forever begin
    bit ex, psh;
    @(negedge clk);
    if (started) begin
      ex  = m_exec && (rst_n === 1'b1);
      psh = ex && (m_op != 1);
      check("call_ack", 16'(call_ack), 16'(ex && m_op == 0));
      check("ret_ack", 16'(ret_ack), 16'(ex && m_op == 1));
      check("irq_ack", 16'(irq_ack), 16'(ex && m_op == 2));
      check("stk_push", 16'(stk_push), 16'(psh));
      check("stk_pop", 16'(stk_pop), 16'(ex && m_op == 1 && mq.size() > 0));
      check("stk_in", 16'(stk_in), psh ? 16'(m_addr) : 16'h0000);
      check("busy", 16'(busy), 16'(m_exec));
      check("depth", 16'(depth), 16'(mq.size()));
      check("ret_valid", 16'(ret_valid), 16'(m_rv));
      check("ret_addr", 16'(ret_addr), 16'(m_ra));
      check("ovf_err", 16'(ovf_err), 16'(m_ovf));
      check("udf_err", 16'(udf_err), 16'(m_udf));
    end
  end

  // Raise one request, wait for its ack (bounded), drop it, return in IDLE.
  task automatic do_op(input int which, input logic [AW-1:0] addr, input bit exp_strobe);
    bit got;
    got = 1'b0;
    case (which)
      0: begin call_addr = addr; call_req = 1'b1; end
      1: ret_req = 1'b1;
      default: begin irq_addr = addr; irq_req = 1'b1; end
    endcase
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = (which == 0) ? call_ack : (which == 1) ? ret_ack : irq_ack;
    end
    check("ack_seen", 16'(got), 16'h0001);
    if (which == 1) check("pop_strobe", 16'(stk_pop), 16'(exp_strobe));
    else begin
      check("push_strobe", 16'(stk_push), 16'h0001);
      check("push_data", 16'(stk_in), 16'(addr));
    end
    call_req = 1'b0; ret_req = 1'b0; irq_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_ret(input logic [AW-1:0] exp_addr, input bit exp_pop);
    do_op(1, '0, exp_pop);
    check("ret_valid_pulse", 16'(ret_valid), 16'h0001);
    check("ret_addr_lit", 16'(ret_addr), 16'(exp_addr));
  endtask

  initial begin
    int order [3];
    int n;
    logic [AW-1:0] seen_ra;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1'b1;
    check("rst_depth", 16'(depth), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_ret", 16'({ret_valid, ret_addr}), 16'h0000);
    check("rst_flags", 16'({ovf_err, udf_err, stk_push, stk_pop}), 16'h0000);

    do_op(0, 9'h0A5, 1'b1);
    check("depth_after_call", 16'(depth), 16'h0001);
    do_ret(9'h0A5, 1'b1);

    do_op(0, 9'h011, 1'b1);
    do_op(0, 9'h022, 1'b1);
    do_ret(9'h022, 1'b1);
    do_ret(9'h011, 1'b1);
    check("lifo_depth", 16'(depth), 16'h0000);
    check("lifo_flags", 16'({ovf_err, udf_err}), 16'h0000);

    do_op(0, 9'h001, 1'b1);
    do_op(0, 9'h002, 1'b1);
    do_op(0, 9'h003, 1'b1);
    check("ovf_set", 16'(ovf_err), 16'h0001);
    check("ovf_depth", 16'(depth), 16'h0002);
    do_ret(9'h003, 1'b1);
    do_ret(9'h002, 1'b1);

    do_ret(9'h000, 1'b0);
    check("udf_set", 16'(udf_err), 16'h0001);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_clr", 16'({ovf_err, udf_err}), 16'h0000);

    do_op(0, 9'h050, 1'b1);
    irq_addr = 9'h1FF; call_addr = 9'h0CC;
    irq_req = 1'b1; ret_req = 1'b1; call_req = 1'b1;
    n = 0;
    seen_ra = 9'h000;
    for (int i = 0; i < 12 && n < 3; i++) begin
      @(posedge clk); #1;
      if (ret_valid) seen_ra = ret_addr;
      if (irq_ack)  begin order[n] = 2; n++; irq_req = 1'b0; end
      if (ret_ack)  begin order[n] = 1; n++; ret_req = 1'b0; end
      if (call_ack) begin order[n] = 0; n++; call_req = 1'b0; end
    end
    check("arb_count", 16'(n), 16'h0003);
    if (n == 3) begin
      check("arb_first_irq", 16'(order[0]), 16'h0002);
      check("arb_second_ret", 16'(order[1]), 16'h0001);
      check("arb_third_call", 16'(order[2]), 16'h0000);
    end
    check("arb_ret_addr", 16'(seen_ra), 16'h01FF);
    @(posedge clk); #1;
    check("arb_depth", 16'(depth), 16'h0002);

    call_addr = 9'h077; call_req = 1'b1;
    @(posedge clk); #1;
    check("exec_busy", 16'(busy), 16'h0001);
    rst_n = 1'b0;
    #1;
    check("abort_ack", 16'(call_ack), 16'h0000);
    check("abort_push", 16'(stk_push), 16'h0000);
    call_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_depth", 16'(depth), 16'h0000);
    check("abort_outs", 16'({busy, ret_valid, ovf_err, udf_err, ret_addr}), 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
